rpn_eval: RTL and testbench

Postfix (RPN) expression sequencer for the arithmetic expression calculator. It consumes a token stream over a valid/ready handshake and drives the operand stack's control and data ports. Operands are pushed, and each operator replaces the top two entries with its result. At end of expression it returns one result with an error code. It sits directly upstream of the operand stack and is the only master of it.

---
 rtl/rpn_eval.sv | 165 ++++++++++++++++
 tb/tb_rpn_eval.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_eval.sv
// Postfix expression sequencer: accepts operand/operator tokens and drives the operand stack.
// Optional feature macro RPN_DIV_EN enables signed division for operator code 3.
module rpn_eval #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_MAX = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_is_op,
  input  logic              tok_last,
  input  logic [DATA_W-1:0] tok_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_err,
  output logic              stk_flush,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_pop2,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic              stk_empty,
  input  logic [DATA_W-1:0] stk_top,
  input  logic [DATA_W-1:0] stk_next,
  output logic [2:0]        dbg_state
);

  localparam int DW = $clog2(DEPTH_MAX + 1);

  // Handshake: a token transfers on a rising edge where tok_valid && tok_ready;
  // a result transfers on a rising edge where res_valid && res_ready. Both
  // ready/valid outputs are registered, so nothing on them depends on the peer.
  typedef enum logic [2:0] {S_FLUSH, S_IN, S_EXEC, S_SETTLE, S_DONE} state_t;

  state_t          state;
  logic [DW-1:0]   depth;
  logic [2:0]      err;
  logic            last_q;
  logic [2:0]      op;
  logic [DATA_W-1:0] alu_y;
  logic            op_legal;
  logic            div_zero;
  logic            unused_stk_empty;

  assign unused_stk_empty = stk_empty;
  assign stk_pop   = 1'b0;
  assign dbg_state = state;
  assign op        = tok_data[2:0];

  // Stack contents are settled while waiting for a token, so the operator
  // result is formed at accept time and presented as registered EXEC outputs.
  always_comb begin
    alu_y    = '0;
    op_legal = 1'b1;
    div_zero = 1'b0;
    case (op)
      3'd0: alu_y = stk_next + stk_top;
      3'd1: alu_y = stk_next - stk_top;
      3'd2: alu_y = stk_next * stk_top;
`ifdef RPN_DIV_EN
      3'd3: begin
        div_zero = (stk_top == '0);
        if (div_zero)
          alu_y = '0;
        else if (stk_top == '1)
          alu_y = '0 - stk_next;
        else
          alu_y = $signed(stk_next) / $signed(stk_top);
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FLUSH;
      depth     <= '0;
      err       <= 3'd0;
      last_q    <= 1'b0;
      tok_ready <= 1'b0;
      stk_flush <= 1'b1;
      stk_push  <= 1'b0;
      stk_pop2  <= 1'b0;
      stk_wdata <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 3'd0;
    end else begin
      stk_flush <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop2  <= 1'b0;
      case (state)
        S_FLUSH: begin
          depth     <= '0;
          err       <= 3'd0;
          res_data  <= '0;
          res_err   <= 3'd0;
          stk_wdata <= '0;
          tok_ready <= 1'b1;
          state     <= S_IN;
        end
        S_IN: begin
          if (tok_valid) begin
            tok_ready <= 1'b0;
            last_q    <= tok_last;
            state     <= S_EXEC;
            if (err == 3'd0) begin
              if (!tok_is_op) begin
                if (depth == DW'(DEPTH_MAX)) begin
                  err <= 3'd2;
                end else begin
                  stk_push  <= 1'b1;
                  stk_wdata <= tok_data;
                  depth     <= depth + DW'(1);
                end
              end else if (!op_legal) begin
                err <= 3'd4;
              end else if (depth < DW'(2)) begin
                err <= 3'd1;
              end else if (div_zero) begin
                err <= 3'd5;
              end else begin
                stk_push  <= 1'b1;
                stk_pop2  <= 1'b1;
                stk_wdata <= alu_y;
                depth     <= depth - DW'(1);
              end
            end
          end
        end
        S_EXEC: state <= S_SETTLE;
        S_SETTLE: begin
          if (last_q) begin
            res_valid <= 1'b1;
            state     <= S_DONE;
            if (err != 3'd0) begin
              res_err <= err;
            end else if (depth == DW'(1)) begin
              res_data <= stk_top;
            end else begin
              err     <= 3'd3;
              res_err <= 3'd3;
            end
          end else begin
            tok_ready <= 1'b1;
            state     <= S_IN;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 3'd0;
            stk_flush <= 1'b1;
            state     <= S_FLUSH;
          end
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval: behavioural operand stack, queue-based expression model,
// directed expressions from the test plan plus randomized expressions.
module tb_rpn_eval;

  logic        clk, rst;
  logic        tok_valid, tok_ready, tok_is_op, tok_last;
  logic [31:0] tok_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_err;
  logic        stk_flush, stk_push, stk_pop, stk_pop2;
  logic [31:0] stk_wdata, stk_top, stk_next;
  logic        stk_empty;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef RPN_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  rpn_eval #(.DATA_W(32), .DEPTH_MAX(63)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_last(tok_last), .tok_data(tok_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .stk_flush(stk_flush), .stk_push(stk_push), .stk_pop(stk_pop), .stk_pop2(stk_pop2),
    .stk_wdata(stk_wdata), .stk_empty(stk_empty), .stk_top(stk_top), .stk_next(stk_next),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // operand stack
  logic [31:0] mem [0:255];
  int sp = 0;
  always @(posedge clk) begin
    if (stk_flush) sp <= 0;
    else if (stk_push && stk_pop2) begin
      mem[sp-2] <= stk_wdata;
      sp <= sp - 1;
    end else if (stk_push) begin
      mem[sp] <= stk_wdata;
      sp <= sp + 1;
    end
  end
  assign stk_top   = (sp >= 1 && sp <= 256) ? mem[sp-1] : '0;
  assign stk_next  = (sp >= 2 && sp <= 257) ? mem[sp-2] : '0;
  assign stk_empty = (sp == 0);

  // expression under test and reference model
  bit          tq_op [$];
  logic [31:0] tq_dat [$];

  function automatic void model(output logic [2:0] e, output logic [31:0] d, output int sz);
    logic [31:0] st [$];
    logic [31:0] a, b, r;
    logic [31:0] w;
    logic [2:0]  code;
    longint      q;
    e = 3'd0;
    d = '0;
    foreach (tq_op[i]) begin
      if (e != 3'd0) continue;
      if (!tq_op[i]) begin
        if (st.size() == 63) e = 3'd2;
        else st.push_back(tq_dat[i]);
      end else begin
        w = tq_dat[i];
        code = w[2:0];
        if (code > 3'd3 || (code == 3'd3 && !DIV_EN)) e = 3'd4;
        else if (st.size() < 2) e = 3'd1;
        else begin
          b = st[st.size()-1];
          a = st[st.size()-2];
          r = '0;
          if (code == 3'd3 && b == 32'd0) e = 3'd5;
          else begin
            case (code)
              3'd0: r = a + b;
              3'd1: r = a - b;
              3'd2: r = a * b;
              default: begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = q[31:0];
              end
            endcase
            void'(st.pop_back());
            void'(st.pop_back());
            st.push_back(r);
          end
        end
      end
    end
    if (e == 3'd0 && st.size() != 1) e = 3'd3;
    if (e == 3'd0) d = st[0];
    sz = st.size();
  endfunction

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clr();
    tq_op.delete();
    tq_dat.delete();
  endtask

  task automatic add_num(logic [31:0] v);
    tq_op.push_back(1'b0);
    tq_dat.push_back(v);
  endtask

  task automatic add_op(logic [2:0] code);
    logic [31:0] v;
    v = $urandom;
    v[2:0] = code;
    tq_op.push_back(1'b1);
    tq_dat.push_back(v);
  endtask

  task automatic send_tok(bit is_op, logic [31:0] data, bit last);
    int n = 0;
    int k = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = data;
    tok_last  = last;
    while (tok_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("tok_ready_timeout", 96'(tok_ready), 96'(1));
    @(posedge clk);
    #1 tok_valid = 1'b0;
    if (!last) begin
      do begin
        @(negedge clk);
        k++;
      end while (tok_ready !== 1'b1 && k < 20);
      chk("token_spacing", 96'(k), 96'(3));
    end
  endtask

  task automatic run_expr(string tag, int hold, bit use_k, logic [2:0] k_err, logic [31:0] k_dat);
    logic [2:0]  m_err;
    logic [31:0] m_dat;
    int          m_sz;
    int          n = 0;
    model(m_err, m_dat, m_sz);
    if (use_k) begin
      m_err = k_err;
      m_dat = k_dat;
    end
    foreach (tq_op[i]) send_tok(tq_op[i], tq_dat[i], i == tq_op.size() - 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_res_early"}, 96'(res_valid), 96'(0));
    @(negedge clk);
    chk({tag, "_res_latency"}, 96'(res_valid), 96'(1));
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_err"}, 96'(res_err), 96'(m_err));
    chk({tag, "_data"}, 96'(res_data), 96'(m_dat));
    chk({tag, "_depth"}, 96'(sp), 96'(m_sz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {res_valid, tok_ready, res_err, res_data},
          {1'b1, 1'b0, m_err, m_dat});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_flush"}, {stk_flush, res_valid, tok_ready}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk({tag, "_ready_after_flush"}, {tok_ready, 32'(sp)}, {1'b1, 32'd0});
  endtask

  task automatic gen_random();
    int d = 0;
    int len = $urandom_range(1, 12);
    clr();
    for (int i = 0; i < len; i++) begin
      if (d >= 2 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) == 0) add_op(3'($urandom_range(4, 7)));
        else add_op(3'($urandom_range(0, 3)));
        d--;
      end else begin
        if ($urandom_range(0, 2) == 0) add_num($urandom_range(0, 4) - 2);
        else add_num($urandom);
        d++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_last = 1'b0; tok_data = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tok_ready, res_valid, res_err, res_data, stk_push, stk_pop, stk_pop2, stk_wdata}, '0);
    rst = 1'b0;
    #1 chk("flush_after_reset", {stk_flush, tok_ready}, {1'b1, 1'b0});
    @(negedge clk);
    chk("ready_after_reset", {tok_ready, stk_flush}, {1'b1, 1'b0});

    clr(); add_num(3); add_num(4); add_op(0); add_num(2); add_op(2);
    run_expr("add_mul", 0, 1'b1, 3'd0, 32'd14);

    clr(); add_num(5); add_op(0);
    run_expr("underflow", 0, 1'b1, 3'd1, 32'd0);
    clr(); add_num(7);
    run_expr("single", 0, 1'b1, 3'd0, 32'd7);

    clr(); add_num(1); add_num(2);
    run_expr("depth_two", 0, 1'b1, 3'd3, 32'd0);

    clr();
    for (int i = 0; i < 64; i++) add_num($urandom);
    run_expr("overflow", 0, 1'b1, 3'd2, 32'd0);

    clr(); add_num(10); add_num(3); add_op(1);
    run_expr("sub_hold", 5, 1'b1, 3'd0, 32'd7);

    clr(); add_num(-32'sd7); add_num(2); add_op(3);
`ifdef RPN_DIV_EN
    run_expr("div_neg", 0, 1'b1, 3'd0, -32'sd3);
    clr(); add_num(1); add_num(0); add_op(3);
    run_expr("div_zero", 0, 1'b1, 3'd5, 32'd0);
    clr(); add_num(32'h8000_0000); add_num(32'hFFFF_FFFF); add_op(3);
    run_expr("div_min", 0, 1'b1, 3'd0, 32'h8000_0000);
`else
    run_expr("div_disabled", 0, 1'b1, 3'd4, 32'd0);
`endif

    clr(); add_num(1); add_num(2); add_op(5);
    run_expr("illegal_op", 0, 1'b1, 3'd4, 32'd0);

    clr(); add_num(5); add_op(0); add_num(1); add_num(2); add_op(6);
    run_expr("first_err_wins", 0, 1'b1, 3'd1, 32'd0);

    clr(); add_num(32'h0001_0001); add_num(32'h0001_0001); add_op(2); add_num(32'hFFFF_FFFF); add_op(0);
    run_expr("wrap", 0, 1'b1, 3'd0, 32'h0002_0000);

    for (int t = 0; t < 20; t++) begin
      gen_random();
      run_expr("random", $urandom_range(0, 2), 1'b0, 3'd0, 32'd0);
    end

    // reset while executing an operator
    send_tok(1'b0, 32'd1, 1'b0);
    send_tok(1'b0, 32'd2, 1'b0);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 32'd0; tok_last = 1'b0;
    @(posedge clk);
    #1 tok_valid = 1'b0;
    chk("exec_push", {stk_push, stk_pop2, stk_wdata}, {1'b1, 1'b1, 32'd3});
    rst = 1'b1;
    #1 chk("mid_reset_outputs", {tok_ready, res_valid, res_err, res_data, stk_push, stk_pop, stk_pop2, stk_wdata}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_reset_flush", {stk_flush, tok_ready}, {1'b1, 1'b0});
    @(negedge clk);
    chk("mid_reset_ready", {tok_ready, 32'(sp)}, {1'b1, 32'd0});
    clr(); add_num(2); add_num(3); add_op(2);
    run_expr("after_reset", 0, 1'b1, 3'd0, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
